// File: rtl/keypad_cmd_if.sv
// Key-press command channel between a test sequencer (master) and the keypad
// emulator (slave).
//   cmd_valid : master offers a command
//   cmd_ready : slave can accept a command this cycle
//   cmd_key   : key code, 0x0-0x9 digits, 0xA-0xD letters, 0xE '*', 0xF '#'
//   cmd_hold  : closed-contact hold time in clk cycles (0 behaves as 1)
interface keypad_cmd_if #(
   parameter int unsigned HOLD_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_key;
   logic [HOLD_W-1:0] cmd_hold;

   modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 matrix keypad emulator: responder end of a column-scan / row-sense
// keypad interface. Accepts key-press commands and pulls the matching row
// low while the emulated contact is closed and its column is driven low.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   cmd         : key-press command channel (slave side of keypad_cmd_if)
//   col         : column drive from the scanner, active-low
//   line        : row sense back to the scanner, active-low, idle 4'b1111
//   busy        : a command is in progress
//   done        : one-cycle pulse on the last cycle of a command
//   press_count : completed presses, wraps 255 -> 0
//
// Build option: define KEYPAD_EMU_BOUNCE_EN to add contact bounce phases on
// press and release (BOUNCE_IN / BOUNCE_OUT). Without it the flow is
// IDLE -> HOLD -> GAP with clean contact edges.
module keypad_matrix_emulator #(
   parameter int unsigned HOLD_W         = 16,
   parameter int unsigned BOUNCE_TOGGLES = 6,
   parameter int unsigned BOUNCE_PERIOD  = 4,
   parameter int unsigned GAP_CYCLES     = 64
) (
   input  logic             clk,
   input  logic             reset,
   keypad_cmd_if.slave      cmd,
   input  logic [3:0]       col,
   output logic [3:0]       line,
   output logic             busy,
   output logic             done,
   output logic [7:0]       press_count
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // One shared down-counter serves hold, gap and bounce-period timing.
   localparam int unsigned CNT_W = max2(max2(HOLD_W, $clog2(GAP_CYCLES)),
                                        max2(max2($clog2(BOUNCE_PERIOD), $clog2(BOUNCE_TOGGLES)), 1));
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(BOUNCE_PERIOD - 1);
   localparam logic [CNT_W-1:0] TOG_LAST = CNT_W'(BOUNCE_TOGGLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_HOLD, S_GAP
   } state_t;
`endif

   state_t           state;
   logic             contact;
   logic [1:0]       key_row;
   logic [1:0]       key_col;
   logic [CNT_W-1:0] cnt;
`ifdef KEYPAD_EMU_BOUNCE_EN
   logic [CNT_W-1:0]  tog;
   logic [HOLD_W-1:0] hold_q;
`endif

   // Key code -> {row, col} position on the 4x4 matrix.
   function automatic logic [3:0] key_pos(input logic [3:0] k);
      logic [3:0] p;
      case (k)
         4'h1: p = 4'b00_00;
         4'h2: p = 4'b00_01;
         4'h3: p = 4'b00_10;
         4'hA: p = 4'b00_11;
         4'h4: p = 4'b01_00;
         4'h5: p = 4'b01_01;
         4'h6: p = 4'b01_10;
         4'hB: p = 4'b01_11;
         4'h7: p = 4'b10_00;
         4'h8: p = 4'b10_01;
         4'h9: p = 4'b10_10;
         4'hC: p = 4'b10_11;
         4'hE: p = 4'b11_00;
         4'h0: p = 4'b11_01;
         4'hF: p = 4'b11_10;
         default: p = 4'b11_11;   // 0xD
      endcase
      return p;
   endfunction

   // Hold counter preload: a zero hold still closes the contact for one cycle.
   function automatic logic [CNT_W-1:0] hold_init(input logic [HOLD_W-1:0] h);
      return (h == '0) ? '0 : CNT_W'(h - HOLD_W'(1));
   endfunction

   // Row sense: only the column matching the held key can pull its row low.
   always_comb begin
      line = 4'b1111;
      if (contact && !col[key_col])
         line[key_row] = 1'b0;
   end

   // Press sequencer with registered contact and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         contact       <= 1'b0;
         key_row       <= 2'd0;
         key_col       <= 2'd0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         press_count   <= 8'd0;
         cmd.cmd_ready <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
         tog           <= '0;
         hold_q        <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               contact <= 1'b0;
               if (cmd.cmd_valid) begin
                  {key_row, key_col} <= key_pos(cmd.cmd_key);
                  contact            <= 1'b1;
                  busy               <= 1'b1;
                  cmd.cmd_ready      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  hold_q             <= cmd.cmd_hold;
                  cnt                <= PER_LAST;
                  tog                <= TOG_LAST;
                  state              <= S_BOUNCE_IN;
`else
                  cnt                <= hold_init(cmd.cmd_hold);
                  state              <= S_HOLD;
`endif
               end
            end

`ifdef KEYPAD_EMU_BOUNCE_EN
            // Contact starts closed and flips each period; the last segment is open.
            S_BOUNCE_IN: begin
               if (cnt == '0) begin
                  if (tog == '0) begin
                     contact <= 1'b1;
                     cnt     <= hold_init(hold_q);
                     state   <= S_HOLD;
                  end else begin
                     contact <= ~contact;
                     tog     <= tog - CNT_ONE;
                     cnt     <= PER_LAST;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
`endif

            S_HOLD: begin
               if (cnt == '0) begin
                  contact <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  cnt     <= PER_LAST;
                  tog     <= TOG_LAST;
                  state   <= S_BOUNCE_OUT;
`else
                  cnt     <= GAP_LAST;
                  state   <= S_GAP;
                  if (GAP_CYCLES == 1) begin
                     done        <= 1'b1;
                     press_count <= press_count + 8'd1;
                  end
`endif
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

`ifdef KEYPAD_EMU_BOUNCE_EN
            // Contact starts open and flips each period; the last segment is closed.
            S_BOUNCE_OUT: begin
               if (cnt == '0) begin
                  if (tog == '0) begin
                     contact <= 1'b0;
                     cnt     <= GAP_LAST;
                     state   <= S_GAP;
                     if (GAP_CYCLES == 1) begin
                        done        <= 1'b1;
                        press_count <= press_count + 8'd1;
                     end
                  end else begin
                     contact <= ~contact;
                     tog     <= tog - CNT_ONE;
                     cnt     <= PER_LAST;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
`endif

            // done is raised while entering the final gap cycle so it lines up with it.
            S_GAP: begin
               contact <= 1'b0;
               if (cnt == '0) begin
                  busy          <= 1'b0;
                  cmd.cmd_ready <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     done        <= 1'b1;
                     press_count <= press_count + 8'd1;
                  end
               end
            end

            default: begin
               contact       <= 1'b0;
               busy          <= 1'b0;
               cmd.cmd_ready <= 1'b1;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed self-checking bench for keypad_matrix_emulator. Expected line /
// busy / done values come from a per-cycle timeline model of one press.
module tb_keypad_matrix_emulator;

   localparam int unsigned HOLD_W = 8;
   localparam int unsigned GAP    = 64;
   localparam int unsigned BP     = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int unsigned BL     = 24;
`else
   localparam int unsigned BL     = 0;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col   = 4'b1111;
   logic [3:0] line;
   logic       busy;
   logic       done;
   logic [7:0] press_count;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] exp_count = 8'd0;

   logic [3:0] keymap [4][4];
   logic [3:0] rot    [6];

   keypad_cmd_if #(.HOLD_W(HOLD_W)) cmd_bus ();

   keypad_matrix_emulator #(
      .HOLD_W     (HOLD_W),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd_bus.slave),
      .col         (col),
      .line        (line),
      .busy        (busy),
      .done        (done),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic find_key(input logic [3:0] key, output int unsigned r, output int unsigned c);
      r = 0;
      c = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (keymap[i][j] == key) begin
               r = i;
               c = j;
            end
   endtask

   // Expected contact state on cycle k (1 = first cycle after the accept edge).
   function automatic bit model_contact(input int unsigned k, input int unsigned h);
      if (k <= BL)            return ((k - 1) / BP) % 2 == 0;
      else if (k <= BL + h)   return 1'b1;
      else if (k <= 2*BL + h) return ((k - BL - h - 1) / BP) % 2 == 1;
      else                    return 1'b0;
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
   task automatic send(input logic [3:0] key, input logic [HOLD_W-1:0] hold);
      check("ready_before_send", cmd_bus.cmd_ready, 1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_key   = key;
      cmd_bus.cmd_hold  = hold;
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_key   = ~key;
      cmd_bus.cmd_hold  = ~hold;
      @(negedge clk);
   endtask

   // Full press checked cycle by cycle; optionally rotates the column drive.
   task automatic run_press(input logic [3:0] key, input int unsigned hold, input bit rotate, input string tag);
      int unsigned r, c, h, t;
      logic [3:0]  low, exp_line;
      find_key(key, r, c);
      low = ~(4'b0001 << r);
      h   = (hold == 0) ? 1 : hold;
      t   = 2*BL + h + GAP;
      col = ~(4'b0001 << c);
      send(key, HOLD_W'(hold));
      exp_count = exp_count + 8'd1;
      for (int unsigned k = 1; k <= t + 1; k++) begin
         if (rotate) col = rot[k % 6];
         #1;
         exp_line = (model_contact(k, h) && col[c] == 1'b0) ? low : 4'b1111;
         check($sformatf("%s_k%0d_line_busy_done", tag, k), {line, busy, done},
               {exp_line, k <= t, k == t});
         @(negedge clk);
      end
      check({tag, "_count"}, press_count, exp_count);
      check({tag, "_ready_after"}, cmd_bus.cmd_ready, 1);
   endtask

   initial begin
      keymap[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
      keymap[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
      keymap[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
      keymap[3] = '{4'hE, 4'h0, 4'hF, 4'hD};
      rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000};

      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_key   = 4'h0;
      cmd_bus.cmd_hold  = '0;
      col               = 4'b0000;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_line", line, 4'b1111);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", press_count, 0);
      check("rst_ready", cmd_bus.cmd_ready, 1);
      reset = 1'b1;
      col   = 4'b1111;
      @(negedge clk);
      check("idle_line", line, 4'b1111);

      // Key 5, hold 10, fixed column
      run_press(4'h5, 10, 1'b0, "k5_h10");
      // Key 5, rotating and multi-low columns, including scanner idle
      run_press(4'h5, 10, 1'b1, "k5_rot");
      // Key '#', hold 20
      run_press(4'hF, 20, 1'b0, "kF_h20");
      // Zero hold behaves as one cycle
      run_press(4'hA, 0, 1'b0, "kA_h0");
      // Maximum hold value
      run_press(4'h6, 255, 1'b0, "k6_hmax");

      // Commands while busy: a one-cycle offer is dropped, a held offer starts after done
      begin
         int unsigned t1, t2;
         t1  = 2*BL + 5 + GAP;
         t2  = 2*BL + 3 + GAP;
         col = 4'b1110;
         send(4'h1, HOLD_W'(5));
         repeat (BL + 1) @(negedge clk);
         cmd_bus.cmd_valid = 1'b1;
         cmd_bus.cmd_key   = 4'h9;
         cmd_bus.cmd_hold  = HOLD_W'(7);
         #1;
         check("busy_ready_low", cmd_bus.cmd_ready, 0);
         check("busy_line", line, 4'b1110);
         @(negedge clk);
         cmd_bus.cmd_valid = 1'b0;
         @(negedge clk);
         cmd_bus.cmd_valid = 1'b1;
         cmd_bus.cmd_key   = 4'h2;
         cmd_bus.cmd_hold  = HOLD_W'(3);
         #1;
         check("busy_ready_low2", cmd_bus.cmd_ready, 0);
         repeat (t1 - BL - 4) @(negedge clk);
         exp_count = exp_count + 8'd1;
         check("busy_done", {done, cmd_bus.cmd_ready}, 2'b10);
         check("busy_count", press_count, exp_count);
         col = 4'b1101;
         @(negedge clk);
         check("after_done_ready", {cmd_bus.cmd_ready, busy}, 2'b10);
         @(posedge clk);
         #1;
         cmd_bus.cmd_valid = 1'b0;
         cmd_bus.cmd_key   = 4'h0;
         @(negedge clk);
         check("second_busy", busy, 1);
         check("second_line", line, 4'b1110);
         repeat (t2 - 1) @(negedge clk);
         exp_count = exp_count + 8'd1;
         check("second_done", done, 1);
         check("second_count", press_count, exp_count);
         repeat (3) @(negedge clk);
         check("no_queue_busy", busy, 0);
      end

      // Asynchronous reset during HOLD
      col = 4'b1110;
      send(4'h1, HOLD_W'(50));
      repeat (BL + 4) @(negedge clk);
      check("pre_rst_line", line, 4'b1110);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_line", line, 4'b1111);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_count", press_count, 0);
      check("mid_rst_ready", cmd_bus.cmd_ready, 1);
      exp_count = 8'd0;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_done", done, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_line", line, 4'b1111);
      run_press(4'h0, 2, 1'b0, "k0_post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
